// File: rtl/logic_unit_pipe_if.sv
// Handshake and data bundle for logic_unit_pipe: upstream beat channel plus
// downstream result channel. The master drives operands and out_ready, the
// slave (the unit) drives in_ready and the result fields.
interface logic_unit_pipe_if #(
  parameter int WIDTH = 32
);
  localparam int CW = $clog2(WIDTH + 1);

  logic             in_valid;
  logic             in_ready;
  logic [2:0]       in_op;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             in_acc;
  logic             in_last;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_y;
  logic             out_zero;
  logic             out_parity;
  logic [CW-1:0]    out_ones;

  modport master (
    output in_valid, in_op, in_a, in_b, in_acc, in_last, out_ready,
    input  in_ready, out_valid, out_y, out_zero, out_parity, out_ones
  );

  modport slave (
    input  in_valid, in_op, in_a, in_b, in_acc, in_last, out_ready,
    output in_ready, out_valid, out_y, out_zero, out_parity, out_ones
  );
endinterface

// File: rtl/logic_unit_pipe.sv
// Two-stage bitwise logic unit. Stage 1 holds the selected logic result (or
// the closing value of an accumulate group); stage 2 is the output register
// with zero/parity/ones-count flags. An accumulate group folds operand A into
// a private register beat by beat and emits only on its last beat.
module logic_unit_pipe #(
  parameter int WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  logic_unit_pipe_if.slave     bus
);
  localparam int CW = $clog2(WIDTH + 1);

  function automatic logic [WIDTH-1:0] logic_op(input logic [2:0] op,
                                                input logic [WIDTH-1:0] x,
                                                input logic [WIDTH-1:0] y);
    logic [WIDTH-1:0] r;
    case (op)
      3'b000:  r = x & y;
      3'b001:  r = x | y;
      3'b010:  r = x ^ y;
      3'b011:  r = ~(x | y);
      3'b100:  r = ~x;
      3'b101:  r = ~(x & y);
      3'b110:  r = ~(x ^ y);
      default: r = x & ~y;
    endcase
    return r;
  endfunction

  function automatic logic [CW-1:0] ones_count(input logic [WIDTH-1:0] v);
    logic [CW-1:0] c;
    c = '0;
    for (int i = 0; i < WIDTH; i++) c = c + CW'(v[i]);
    return c;
  endfunction

  logic             adv1, adv2, accept, emit;
  logic [WIDTH-1:0] base, s1_next;
  logic [WIDTH-1:0] acc_q;
  logic             acc_open;
  logic             vld_p1, vld_p2;
  logic [WIDTH-1:0] y_p1, y_p2;
  logic             zero_p2, parity_p2;
  logic [CW-1:0]    ones_p2;

  // Stall chain and next stage-1 value; in_ready follows out_ready with no skid
  always_comb begin
    adv2    = ~vld_p2 | bus.out_ready;
    adv1    = ~vld_p1 | adv2;
    accept  = bus.in_valid & adv1;
    base    = acc_open ? logic_op(bus.in_op, acc_q, bus.in_a) : bus.in_a;
    s1_next = bus.in_acc ? base : logic_op(bus.in_op, bus.in_a, bus.in_b);
    emit    = accept & (~bus.in_acc | bus.in_last);
  end

  // Accumulate group state; normal beats leave it untouched
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q    <= '0;
      acc_open <= 1'b0;
    end else if (accept && bus.in_acc) begin
      if (bus.in_last) begin
        acc_open <= 1'b0;
      end else begin
        acc_q    <= base;
        acc_open <= 1'b1;
      end
    end
  end

  // ---- stage 1: selected logic result ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) vld_p1 <= 1'b0;
    else if (adv1) vld_p1 <= emit;
  end

  // Stage-1 data only moves when a result is emitted
  always_ff @(posedge clk) begin
    if (emit) y_p1 <= s1_next;
  end

  // ---- stage 2: output register with flags ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p2    <= 1'b0;
      y_p2      <= '0;
      zero_p2   <= 1'b1;
      parity_p2 <= 1'b0;
      ones_p2   <= '0;
    end else if (adv2) begin
      vld_p2 <= vld_p1;
      if (vld_p1) begin
        y_p2      <= y_p1;
        zero_p2   <= (y_p1 == '0);
        parity_p2 <= ^y_p1;
        ones_p2   <= ones_count(y_p1);
      end
    end
  end

  assign bus.in_ready   = adv1;
  assign bus.out_valid  = vld_p2;
  assign bus.out_y      = y_p2;
  assign bus.out_zero   = zero_p2;
  assign bus.out_parity = parity_p2;
  assign bus.out_ones   = ones_p2;
endmodule

// File: tb/tb_logic_unit_pipe.sv
// Randomized bench for logic_unit_pipe with a queue-based reference model;
// also exercises narrow widths 1 and 7.
module tb_logic_unit_pipe;
  localparam int W = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic_unit_pipe_if #(.WIDTH(W)) bus ();
  logic_unit_pipe_if #(.WIDTH(1)) b1 ();
  logic_unit_pipe_if #(.WIDTH(7)) b7 ();

  logic_unit_pipe #(.WIDTH(W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  logic_unit_pipe #(.WIDTH(1)) u1  (.clk(clk), .rst_n(rst_n), .bus(b1));
  logic_unit_pipe #(.WIDTH(7)) u7  (.clk(clk), .rst_n(rst_n), .bus(b7));

  typedef struct {
    logic [W-1:0] y;
    int           pc;
  } exp_t;

  exp_t         q[$];
  int           n_chk = 0;
  int           n_pass = 0;
  int           cyc = 0;
  int           rmode = 0;
  int           pat_idx = 0;
  bit           lat_chk = 0;
  int           stalls = 0;
  logic [W-1:0] m_acc = '0;
  bit           m_open = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  function automatic logic [W-1:0] f_ref(input logic [2:0] op, input logic [W-1:0] x,
                                         input logic [W-1:0] y);
    case (op)
      3'd0: return x & y;
      3'd1: return x | y;
      3'd2: return x ^ y;
      3'd3: return ~(x | y);
      3'd4: return ~x;
      3'd5: return ~(x & y);
      3'd6: return ~(x ^ y);
      default: return x & ~y;
    endcase
  endfunction

  // Reference: what an accepted beat does to the expected-output queue
  task automatic model(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                       input bit acc, input bit last, input int pc);
    logic [W-1:0] v;
    if (!acc) begin
      q.push_back('{y: f_ref(op, a, b), pc: pc});
    end else begin
      v = m_open ? f_ref(op, m_acc, a) : a;
      if (last) begin
        q.push_back('{y: v, pc: pc});
        m_open = 0;
      end else begin
        m_acc  = v;
        m_open = 1;
      end
    end
  endtask

  task automatic send(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                      input bit acc, input bit last);
    bit ok = 0;
    int n = 0;
    int pc;
    while (!ok) begin
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.in_op    = op;
      bus.in_a     = a;
      bus.in_b     = b;
      bus.in_acc   = acc;
      bus.in_last  = last;
      #1;
      ok = bus.in_ready;
      pc = cyc;
      if (!ok) stalls++;
      @(posedge clk);
      if (ok) model(op, a, b, acc, last, pc);
      n++;
      if (!ok && n > 200) begin
        chk("accept_timeout", 64'(n), 64'(200));
        break;
      end
    end
  endtask

  task automatic idle();
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (q.size() != 0 && n < 200) begin
      @(posedge clk);
      n++;
    end
    chk("drain_left", 64'(q.size()), 64'(0));
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // out_ready driver: 0 always 1, 1 fixed pattern, 2 always 0, 3 random
  initial begin
    bit pat[6] = '{1, 0, 0, 1, 0, 1};
    bus.out_ready = 1'b1;
    forever begin
      @(negedge clk);
      case (rmode)
        0: bus.out_ready = 1'b1;
        1: begin bus.out_ready = pat[pat_idx % 6]; pat_idx++; end
        2: bus.out_ready = 1'b0;
        default: bus.out_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Output monitor: every valid cycle must show the queue head
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (rst_n && bus.out_valid) begin
        if (q.size() == 0) begin
          chk("spurious_out", 64'(bus.out_valid), 64'(0));
        end else begin
          e = q[0];
          chk("out_y", 64'(bus.out_y), 64'(e.y));
          chk("out_zero", 64'(bus.out_zero), 64'(e.y == '0));
          chk("out_parity", 64'(bus.out_parity), 64'($countones(e.y) % 2));
          chk("out_ones", 64'(bus.out_ones), 64'($countones(e.y)));
          if (lat_chk) chk("latency", 64'(cyc - e.pc), 64'(2));
          if (bus.out_ready) void'(q.pop_front());
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    bus.in_valid = 0; bus.in_op = 0; bus.in_a = 0; bus.in_b = 0;
    bus.in_acc = 0; bus.in_last = 0;
    b1.in_valid = 0; b1.in_op = 0; b1.in_a = 0; b1.in_b = 0;
    b1.in_acc = 0; b1.in_last = 0; b1.out_ready = 1;
    b7.in_valid = 0; b7.in_op = 0; b7.in_a = 0; b7.in_b = 0;
    b7.in_acc = 0; b7.in_last = 0; b7.out_ready = 1;

    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #2;
    chk("rst_out_valid", 64'(bus.out_valid), 64'(0));
    chk("rst_out_y", 64'(bus.out_y), 64'(0));
    chk("rst_out_zero", 64'(bus.out_zero), 64'(1));
    chk("rst_out_parity", 64'(bus.out_parity), 64'(0));
    chk("rst_out_ones", 64'(bus.out_ones), 64'(0));
    chk("rst_in_ready", 64'(bus.in_ready), 64'(1));

    // All eight ops back to back, no backpressure
    lat_chk = 1;
    for (int op = 0; op < 8; op++) send(3'(op), 32'hF0F0_1234, 32'h0FF0_FFFF, 0, 0);
    idle();
    drain();

    // OR accumulate group, then interleaved normal beat inside an open group
    send(3'b000, 32'h1, 32'hDEAD, 1, 0);
    send(3'b001, 32'h2, 32'hDEAD, 1, 0);
    send(3'b001, 32'h8, 32'hDEAD, 1, 1);
    send(3'b000, 32'hFF, 32'h0, 1, 0);
    send(3'b010, 32'hAA, 32'h0F, 0, 0);
    send(3'b000, 32'h0F, 32'h0, 1, 1);
    idle();
    drain();
    lat_chk = 0;

    // Backpressure pattern with six beats
    stalls = 0;
    pat_idx = 0;
    rmode = 1;
    for (int i = 0; i < 6; i++) send(3'($urandom_range(0, 7)), $urandom, $urandom, 0, 0);
    idle();
    drain();
    chk("bp_stall_seen", 64'(stalls > 0), 64'(1));

    // Random mix of normal and accumulate beats with random backpressure
    rmode = 3;
    for (int i = 0; i < 300; i++) begin
      bit acc;
      acc = ($urandom_range(0, 2) == 0);
      send(3'($urandom_range(0, 7)), $urandom, $urandom, acc, ($urandom_range(0, 2) == 0));
      if ($urandom_range(0, 4) == 0) idle();
    end
    idle();
    send(3'b001, 32'h0, 32'h0, 1, 1);
    idle();
    rmode = 0;
    drain();

    // Reset with an open group and a stalled full pipe
    send(3'b000, 32'hFF00, 32'h0, 1, 0);
    rmode = 2;
    send(3'b001, 32'h1234, 32'h1, 0, 0);
    send(3'b010, 32'h5678, 32'h3, 0, 0);
    idle();
    repeat (3) @(posedge clk);
    #3;
    rst_n = 1'b0;
    q.delete();
    m_open = 0;
    m_acc = '0;
    #1;
    chk("mid_rst_out_valid", 64'(bus.out_valid), 64'(0));
    chk("mid_rst_out_zero", 64'(bus.out_zero), 64'(1));
    chk("mid_rst_out_y", 64'(bus.out_y), 64'(0));
    rmode = 0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("post_rst_in_ready", 64'(bus.in_ready), 64'(1));
    send(3'b010, 32'h5, 32'h0, 1, 1);
    idle();
    drain();

    // Narrow widths: NOT of zero yields all ones
    @(negedge clk);
    b1.in_valid = 1; b1.in_op = 3'b100;
    b7.in_valid = 1; b7.in_op = 3'b100;
    @(negedge clk);
    b1.in_valid = 0;
    b7.in_valid = 0;
    @(negedge clk);
    chk("w1_valid", 64'(b1.out_valid), 64'(1));
    chk("w1_y", 64'(b1.out_y), 64'(1));
    chk("w1_ones", 64'(b1.out_ones), 64'(1));
    chk("w1_parity", 64'(b1.out_parity), 64'(1));
    chk("w7_valid", 64'(b7.out_valid), 64'(1));
    chk("w7_y", 64'(b7.out_y), 64'(7'h7F));
    chk("w7_ones", 64'(b7.out_ones), 64'(7));
    chk("w7_parity", 64'(b7.out_parity), 64'(1));
    chk("w7_zero", 64'(b7.out_zero), 64'(0));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
